conv_transpose1_module: RTL and testbench

//  Decoder-side counterpart of conv1_module: a 1-D transposed convolution (ConvTranspose1d) on

---
 rtl/conv_transpose1_pkg.sv | 46 ++++
 rtl/conv_transpose1_if.sv | 19 +
 rtl/conv_transpose1_mac.sv | 37 +++
 rtl/conv_transpose1_module.sv | 171 +++++++++++++++++
 tb/tb_conv_transpose1_module.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_transpose1_pkg.sv
// Shared Q-format constants, coefficient types, FSM encoding and the output saturation
// helper for the 1-D transposed-convolution layer.
package conv_transpose1_pkg;

  localparam int CT_DW   = 16;
  localparam int CT_FRAC = 8;
  localparam int CT_IC   = 2;
  localparam int CT_OC   = 4;
  localparam int CT_K    = 3;
  localparam int CT_S    = 2;
  localparam int CT_P    = 1;
  localparam int CT_IN   = 2;
  localparam int CT_OUT  = (CT_IN - 1) * CT_S - 2 * CT_P + CT_K;

  // Sum of IC*K full-width products plus a preloaded bias, with one bit of headroom.
  localparam int CT_ACC_W = 2 * CT_DW + $clog2(CT_IC * CT_K) + 1;

  typedef logic [CT_IC-1:0][CT_OC-1:0][CT_K-1:0][CT_DW-1:0] weights_t;
  typedef logic [CT_OC-1:0][CT_DW-1:0]                      bias_t;

  localparam weights_t DEFAULT_WEIGHTS = {(CT_IC * CT_OC * CT_K){16'h0040}};
  localparam bias_t    DEFAULT_BIAS    = '0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t MAC   = 2'd1;
  localparam state_t STORE = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam logic signed [CT_ACC_W-1:0] SAT_MAX = CT_ACC_W'((2 ** (CT_DW - 1)) - 1);
  localparam logic signed [CT_ACC_W-1:0] SAT_MIN = CT_ACC_W'(-(2 ** (CT_DW - 1)));

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Floor back to the data Q-format, then clamp to the representable range.
  function automatic logic signed [CT_DW-1:0] saturate(input logic signed [CT_ACC_W-1:0] acc);
    logic signed [CT_ACC_W-1:0] sh;
    sh = acc >>> CT_FRAC;
    if (sh > SAT_MAX) return CT_DW'(SAT_MAX);
    if (sh < SAT_MIN) return CT_DW'(SAT_MIN);
    return CT_DW'(sh);
  endfunction

endpackage

// File: rtl/conv_transpose1_if.sv
// Start/busy/done handshake and block-wide data/result buses of the transposed-conv layer.
interface conv_transpose1_if
  import conv_transpose1_pkg::*;
#(
  parameter int DW  = CT_DW,
  parameter int IC  = CT_IC,
  parameter int IN  = CT_IN,
  parameter int OC  = CT_OC,
  parameter int OUT = CT_OUT
);
  logic                              i_start;
  logic [IC-1:0][IN-1:0][DW-1:0]     i_data;
  logic                              o_busy;
  logic                              o_done_tick;
  logic [OC-1:0][OUT-1:0][DW-1:0]    o_result;

  modport master (output i_start, i_data, input o_busy, o_done_tick, o_result);
  modport slave  (input i_start, i_data, output o_busy, o_done_tick, o_result);
endinterface

// File: rtl/conv_transpose1_mac.sv
// Single accumulator for the layer: bias preload, gated multiply-accumulate, and the
// floor/saturate path back to the data format.
module conv_transpose1_mac
  import conv_transpose1_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    acc_en,
  input  logic                    tap_valid,
  input  logic signed [CT_DW-1:0] bias,
  input  logic signed [CT_DW-1:0] x,
  input  logic signed [CT_DW-1:0] w,
  output logic signed [CT_DW-1:0] y_sat
);

  logic signed [2*CT_DW-1:0]  prod;
  logic signed [CT_ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    prod  = x * w;
    acc_d = acc_q;
    if (clear)                      acc_d = '0;
    else if (load)                  acc_d = CT_ACC_W'(bias) <<< CT_FRAC;
    else if (acc_en && tap_valid)   acc_d = acc_q + CT_ACC_W'(prod);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign y_sat = saturate(acc_q);

endmodule

// File: rtl/conv_transpose1_module.sv
// ConvTranspose1d layer: walks (oc, of) outputs, spending one cycle per (ic, k) tap on a
// shared MAC and one cycle to store each saturated result; publishes the block atomically.
module conv_transpose1_module
  import conv_transpose1_pkg::*;
#(
  parameter int DATA_WIDTH       = CT_DW,
  parameter int FRACTIONAL_BITS  = CT_FRAC,
  parameter int NUM_IN_CHANNELS  = CT_IC,
  parameter int NUM_OUT_CHANNELS = CT_OC,
  parameter int KERNEL_SIZE      = CT_K,
  parameter int STRIDE           = CT_S,
  parameter int PADDING          = CT_P,
  parameter int NUM_IN_FRAMES    = CT_IN,
  parameter logic [NUM_IN_CHANNELS-1:0][NUM_OUT_CHANNELS-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]
                WEIGHTS = DEFAULT_WEIGHTS,
  parameter logic [NUM_OUT_CHANNELS-1:0][DATA_WIDTH-1:0] BIAS = DEFAULT_BIAS
)(
  input logic              clk,
  input logic              rst_n,
  conv_transpose1_if.slave bus
);

  localparam int NUM_OUT_FRAMES = (NUM_IN_FRAMES - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
  localparam int OCW = cnt_w(NUM_OUT_CHANNELS);
  localparam int OFW = cnt_w(NUM_OUT_FRAMES);
  localparam int ICW = cnt_w(NUM_IN_CHANNELS);
  localparam int KW  = cnt_w(KERNEL_SIZE);
  localparam int INW = cnt_w(NUM_IN_FRAMES);
  localparam logic [OCW-1:0] OC_LAST = OCW'(NUM_OUT_CHANNELS - 1);
  localparam logic [OFW-1:0] OF_LAST = OFW'(NUM_OUT_FRAMES - 1);
  localparam logic [ICW-1:0] IC_LAST = ICW'(NUM_IN_CHANNELS - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(KERNEL_SIZE - 1);

  typedef logic [NUM_IN_CHANNELS-1:0][NUM_IN_FRAMES-1:0][DATA_WIDTH-1:0]   in_blk_t;
  typedef logic [NUM_OUT_CHANNELS-1:0][NUM_OUT_FRAMES-1:0][DATA_WIDTH-1:0] out_blk_t;

  state_t         state_d, state_q;
  logic [OCW-1:0] oc_d, oc_q;
  logic [OFW-1:0] of_d, of_q;
  logic [ICW-1:0] ic_d, ic_q;
  logic [KW-1:0]  k_d, k_q;
  in_blk_t        x_d, x_q;
  out_blk_t       work_d, work_q, result_d, result_q;
  logic           busy_d, busy_q, done_d, done_q;

  logic                         acc_clear, acc_load, acc_en, tap_valid;
  logic [INW-1:0]               in_idx;
  int                           tap_t;
  logic signed [DATA_WIDTH-1:0] y_sat;

  // Output frame o receives input frame i through tap k when o + P - k == i*S.
  always_comb begin
    tap_t     = int'(of_q) + PADDING - int'(k_q);
    tap_valid = (tap_t >= 0) && (tap_t % STRIDE == 0) && (tap_t / STRIDE < NUM_IN_FRAMES);
    in_idx    = tap_valid ? INW'(tap_t / STRIDE) : '0;
  end

  conv_transpose1_mac u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clear),
    .load      (acc_load),
    .acc_en    (acc_en),
    .tap_valid (tap_valid),
    .bias      (BIAS[oc_d]),
    .x         (x_q[ic_q][in_idx]),
    .w         (WEIGHTS[ic_q][oc_q][k_q]),
    .y_sat     (y_sat)
  );

  always_comb begin
    // NOTE: every *_d takes its hold value before the case, so no path infers a latch.
    state_d   = state_q;
    oc_d      = oc_q;
    of_d      = of_q;
    ic_d      = ic_q;
    k_d       = k_q;
    x_d       = x_q;
    work_d    = work_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        x_d      = bus.i_data;
        oc_d     = '0;
        of_d     = '0;
        ic_d     = '0;
        k_d      = '0;
        busy_d   = 1'b1;
        acc_load = 1'b1;
        state_d  = MAC;
      end
      MAC: begin
        acc_en = 1'b1;
        if (k_q == K_LAST) begin
          k_d = '0;
          if (ic_q == IC_LAST) begin
            ic_d    = '0;
            state_d = STORE;
          end else begin
            ic_d = ic_q + ICW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      STORE: begin
        work_d[oc_q][of_q] = y_sat;
        state_d            = MAC;
        acc_load           = 1'b1;
        if (of_q == OF_LAST) begin
          of_d = '0;
          if (oc_q == OC_LAST) begin
            // Final result lands together with the rest of the block on this edge.
            result_d  = work_d;
            done_d    = 1'b1;
            acc_load  = 1'b0;
            acc_clear = 1'b1;
            state_d   = DONE;
          end else begin
            oc_d = oc_q + OCW'(1);
          end
        end else begin
          of_d = of_q + OFW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the working and result arrays are small register files, reset so a
  // mid-job reset leaves o_result reading zero rather than stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      oc_q     <= '0;
      of_q     <= '0;
      ic_q     <= '0;
      k_q      <= '0;
      x_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      oc_q     <= oc_d;
      of_q     <= of_d;
      ic_q     <= ic_d;
      k_q      <= k_d;
      x_q      <= x_d;
      work_q   <= work_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done_tick = done_q;
  assign bus.o_result    = result_q;

endmodule

// File: tb/tb_conv_transpose1_module.sv
// Directed bench for conv_transpose1_module: hand-computed result blocks are queued at
// stimulus time and popped by per-DUT monitors on each done pulse.
module tb_conv_transpose1_module;
  import conv_transpose1_pkg::*;

  typedef logic [CT_IC-1:0][CT_IN-1:0][CT_DW-1:0]  in_blk_t;
  typedef logic [CT_OC-1:0][CT_OUT-1:0][CT_DW-1:0] out_blk_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec    = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_done_b = 0;
  out_blk_t exp_q[$];
  out_blk_t exp_b_q[$];

  conv_transpose1_if bus ();
  conv_transpose1_if bus_b ();

  conv_transpose1_module #(
    .WEIGHTS ({24{16'h0100}}),
    .BIAS    ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  conv_transpose1_module #(
    .WEIGHTS ({24{16'h0100}}),
    .BIAS    ({16'h0200, 16'h0000, 16'hFF00, 16'h0100})
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic in_blk_t mk_in(input logic [15:0] a, b, c, d);
    in_blk_t v;
    v[0][0] = a; v[0][1] = b; v[1][0] = c; v[1][1] = d;
    return v;
  endfunction

  function automatic out_blk_t rep3(input logic [15:0] y0, y1, y2);
    out_blk_t r;
    for (int oc = 0; oc < CT_OC; oc++) begin
      r[oc][0] = y0; r[oc][1] = y1; r[oc][2] = y2;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.o_done_tick === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL result: unexpected done pulse, got %h, required no completion", bus.o_result);
      end else check("result", bus.o_result, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus_b.o_done_tick === 1'b1) begin
      n_done_b++;
      if (exp_b_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL result_b: unexpected done pulse, got %h, required no completion", bus_b.o_result);
      end else check("result_b", bus_b.o_result, exp_b_q.pop_front());
    end
  end

  task automatic drive(input int which, input logic st, input in_blk_t d);
    if (which == 0) begin bus.i_start = st; bus.i_data = d; end
    else begin bus_b.i_start = st; bus_b.i_data = d; end
  endtask

  task automatic start_job(input int which, input in_blk_t d, output int c0);
    drive(which, 1'b1, d);
    @(posedge clk); #1;
    c0 = cyc;
    drive(which, 1'b0, d);
  endtask

  task automatic wait_done(input int which, input int c0, input int budget, input int req_lat,
                           input string name);
    int lat;
    logic dn;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      dn = (which == 0) ? bus.o_done_tick : bus_b.o_done_tick;
      if (dn === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    check(name, lat, req_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0;
    in_blk_t x1, x_alt, x6;
    x1    = mk_in(16'd256, 16'd512, 16'hFF80, 16'd64);
    x_alt = mk_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    x6    = mk_in(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.o_busy, 1'b0);
    check("reset_done", bus.o_done_tick, 1'b0);
    check("reset_result", bus.o_result, '0);
    check("reset_result_b", bus_b.o_result, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic upsample: every output channel sees the same sums with unit weights.
    exp_q.push_back(rep3(16'd128, 16'd704, 16'd576));
    start_job(0, x1, c0);
    check("t1_busy_after_start", bus.o_busy, 1'b1);
    wait_done(0, c0, 200, 84, "t1_latency");
    @(posedge clk); #1;
    check("t1_busy_fall", bus.o_busy, 1'b0);
    check("t1_done_width", bus.o_done_tick, 1'b0);

    // Saturation at both rails.
    exp_q.push_back(rep3(16'h7FFF, 16'h7FFF, 16'h7FFF));
    start_job(0, mk_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), c0);
    wait_done(0, c0, 200, 84, "t2_pos_latency");
    @(posedge clk); #1;
    exp_q.push_back(rep3(16'h8000, 16'h8000, 16'h8000));
    start_job(0, mk_in(16'h8000, 16'h8000, 16'h8000, 16'h8000), c0);
    wait_done(0, c0, 200, 84, "t2_neg_latency");
    @(posedge clk); #1;

    // Bias only.
    begin
      out_blk_t eb;
      for (int f = 0; f < CT_OUT; f++) begin
        eb[0][f] = 16'h0100; eb[1][f] = 16'hFF00; eb[2][f] = 16'h0000; eb[3][f] = 16'h0200;
      end
      exp_b_q.push_back(eb);
    end
    start_job(1, '0, c0);
    wait_done(1, c0, 200, 84, "t3_latency");
    @(posedge clk); #1;
    check("t3_done_width", bus_b.o_done_tick, 1'b0);
    check("t3_busy_fall", bus_b.o_busy, 1'b0);

    // Start request and data change mid-job are ignored.
    exp_q.push_back(rep3(16'd128, 16'd704, 16'd576));
    start_job(0, x1, c0);
    repeat (19) @(posedge clk);
    #1;
    drive(0, 1'b1, x_alt);
    @(posedge clk); #1;
    drive(0, 1'b0, x_alt);
    check("t4_busy_mid", bus.o_busy, 1'b1);
    wait_done(0, c0, 200, 84, "t4_latency");
    @(posedge clk); #1;
    d0 = n_done;
    repeat (100) @(posedge clk);
    #1;
    check("t4_no_extra_done", n_done, d0);

    // Reset mid-job abandons it.
    start_job(0, x1, c0);
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy_reset", bus.o_busy, 1'b0);
    check("t5_result_reset", bus.o_result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = n_done;
    repeat (100) @(posedge clk);
    #1;
    check("t5_no_done", n_done, d0);
    exp_q.push_back(rep3(16'd128, 16'd704, 16'd576));
    start_job(0, x1, c0);
    wait_done(0, c0, 200, 84, "t5_restart_latency");
    @(posedge clk); #1;

    // Floor of a tiny negative, with i_start held for two back-to-back jobs.
    exp_q.push_back(rep3(16'hFFFF, 16'hFFFF, 16'h0000));
    exp_q.push_back(rep3(16'hFFFF, 16'hFFFF, 16'h0000));
    drive(0, 1'b1, x6);
    @(posedge clk); #1;
    c0 = cyc;
    wait_done(0, c0, 200, 84, "t6_first_latency");
    @(posedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, x6);
    check("t6_busy_restart", bus.o_busy, 1'b1);
    wait_done(0, c0, 300, 170, "t6_second_latency");
    @(posedge clk); #1;

    repeat (5) @(posedge clk);
    #1;
    check("queues_drained", exp_q.size() + exp_b_q.size(), 0);
    check("done_count", n_done, 7);
    check("done_count_b", n_done_b, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
